// File: rtl/rx_ctrl_pkg.sv
// Shared definitions for the UART receive frame controller: state encoding,
// bit-index constants and the prescale floor.
package rx_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    CHECK  = 3'd5
  } rx_state_e;

  localparam int unsigned START_IDX     = 0;
  localparam int unsigned PAR_IDX       = 9;
  localparam int unsigned LAST_DATA_IDX = 8;
  localparam int unsigned MIN_PRESCALE  = 4;
  localparam int unsigned BIT_CNT_W     = 4;

  // Prescale values below the floor would leave no room for a mid-bit sample.
  function automatic int unsigned clamp_prescale(input int unsigned p);
    return (p < MIN_PRESCALE) ? MIN_PRESCALE : p;
  endfunction

endpackage

// File: rtl/rx_frame_ctrl_if.sv
// Signal bundle between the receive frame controller (slave) and the
// surrounding receiver datapath / test driver (master).
//
// Data_valid, stop_err and par_err_o are single-cycle pulses with no
// back-pressure: there is no ready, so the consumer must capture them in the
// cycle they are high. sample_one_bit / sample_three_bit are likewise
// single-cycle strobes to the sampling register.
interface rx_frame_ctrl_if #(
  parameter int PRESCALE_W = 6
);
  logic                  RX_IN;
  logic [PRESCALE_W-1:0] Prescale;
  logic                  PAR_EN;
  logic                  start_bit;
  logic                  stop_bit;
  logic                  par_err;
  logic [3:0]            BIT_COUNT;
  logic                  sample_one_bit;
  logic                  sample_three_bit;
  logic                  Data_valid;
  logic                  stop_err;
  logic                  par_err_o;
  logic                  busy;

  modport master (
    output RX_IN, Prescale, PAR_EN, start_bit, stop_bit, par_err,
    input  BIT_COUNT, sample_one_bit, sample_three_bit, Data_valid,
           stop_err, par_err_o, busy
  );

  modport slave (
    input  RX_IN, Prescale, PAR_EN, start_bit, stop_bit, par_err,
    output BIT_COUNT, sample_one_bit, sample_three_bit, Data_valid,
           stop_err, par_err_o, busy
  );

endinterface

// File: rtl/rx_edge_bit_counter.sv
// Edge counter (0..prescale-1 within a bit) and bit counter (index of the
// bit being received). Clear has priority over enable; wrap flags the last
// edge of the current bit.
module rx_edge_bit_counter #(
  parameter int PRESCALE_W = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en_i,
  input  logic                  clr_i,
  input  logic [PRESCALE_W-1:0] prescale_i,
  output logic [PRESCALE_W-1:0] edge_cnt_o,
  output logic [3:0]            bit_cnt_o,
  output logic                  wrap_o
);

  localparam logic [PRESCALE_W-1:0] ONE_E = PRESCALE_W'(1);

  logic [PRESCALE_W-1:0] edge_q, edge_d;
  logic [3:0]            bit_q,  bit_d;

  // Wrap is independent of enable so the controller can use it to decide
  // on clear without a combinational loop.
  assign wrap_o     = (edge_q == (prescale_i - ONE_E));
  assign edge_cnt_o = edge_q;
  assign bit_cnt_o  = bit_q;

  // Next-count logic: clear, else advance edge, rolling into the bit counter.
  always_comb begin
    edge_d = edge_q;
    bit_d  = bit_q;
    if (clr_i) begin
      edge_d = '0;
      bit_d  = '0;
    end else if (en_i) begin
      if (wrap_o) begin
        edge_d = '0;
        bit_d  = bit_q + 4'd1;
      end else begin
        edge_d = edge_q + ONE_E;
      end
    end
  end

  // Counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      edge_q <= '0;
      bit_q  <= '0;
    end else begin
      edge_q <= edge_d;
      bit_q  <= bit_d;
    end
  end

endmodule

// File: rtl/rx_frame_ctrl.sv
// UART receive frame controller: walks a frame through start, data,
// optional parity and stop bits, strobes the sampler once per bit at
// mid-bit, and reports the frame outcome in a one-cycle CHECK state.
// Build option RX_MAJORITY_SAMPLE_EN: when defined the mid-bit strobe goes
// to sample_three_bit (majority sampler); otherwise to sample_one_bit.
module rx_frame_ctrl
  import rx_ctrl_pkg::*;
#(
  parameter int PRESCALE_W = 6
) (
  input  logic            clk,
  input  logic            rst,
  rx_frame_ctrl_if.slave  bus,
  output rx_state_e       state_o
);

  localparam logic [PRESCALE_W-1:0] MIN_PS = PRESCALE_W'(MIN_PRESCALE);

  rx_state_e             state_q, state_d;
  logic [PRESCALE_W-1:0] prescale_q, prescale_d;
  logic                  par_en_q, par_en_d;

  logic                  start_frame;
  logic                  counting;
  logic                  cnt_clr;
  logic                  wrap;
  logic                  strobe;
  logic                  in_check;
  logic [PRESCALE_W-1:0] edge_cnt;
  logic [3:0]            bit_cnt;

  assign counting = (state_q == START) || (state_q == DATA) ||
                    (state_q == PARITY) || (state_q == STOP);
  assign in_check = (state_q == CHECK);

  rx_edge_bit_counter #(
    .PRESCALE_W (PRESCALE_W)
  ) u_cnt (
    .clk        (clk),
    .rst        (rst),
    .en_i       (counting),
    .clr_i      (cnt_clr),
    .prescale_i (prescale_q),
    .edge_cnt_o (edge_cnt),
    .bit_cnt_o  (bit_cnt),
    .wrap_o     (wrap)
  );

  // Next-state, counter clear and frame-parameter capture.
  always_comb begin
    state_d     = state_q;
    cnt_clr     = 1'b0;
    start_frame = 1'b0;
    prescale_d  = prescale_q;
    par_en_d    = par_en_q;

    unique case (state_q)
      IDLE: begin
        cnt_clr = 1'b1;
        if (!bus.RX_IN) begin
          state_d     = START;
          start_frame = 1'b1;
        end
      end
      START: begin
        if (wrap && (bit_cnt == 4'(START_IDX))) begin
          // A high start sample means the falling edge was noise.
          if (bus.start_bit) begin
            state_d = IDLE;
            cnt_clr = 1'b1;
          end else begin
            state_d = DATA;
          end
        end
      end
      DATA: begin
        if (wrap && (bit_cnt == 4'(LAST_DATA_IDX))) begin
          state_d = par_en_q ? PARITY : STOP;
        end
      end
      PARITY: begin
        if (wrap && (bit_cnt == 4'(PAR_IDX))) begin
          state_d = STOP;
        end
      end
      STOP: begin
        if (wrap) begin
          state_d = CHECK;
          cnt_clr = 1'b1;
        end
      end
      CHECK: begin
        cnt_clr = 1'b1;
        // A low line here is the start bit of a back-to-back frame.
        if (!bus.RX_IN) begin
          state_d     = START;
          start_frame = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_clr = 1'b1;
      end
    endcase

    // Frame parameters are frozen at frame start; later pin changes are ignored.
    if (start_frame) begin
      prescale_d = PRESCALE_W'(clamp_prescale(32'(bus.Prescale)));
      par_en_d   = bus.PAR_EN;
    end
  end

  // State and latched frame parameters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      prescale_q <= MIN_PS;
      par_en_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      prescale_q <= prescale_d;
      par_en_q   <= par_en_d;
    end
  end

  // One strobe per bit, at the middle edge of the bit.
  assign strobe = counting && (edge_cnt == (prescale_q >> 1));

`ifdef RX_MAJORITY_SAMPLE_EN
  assign bus.sample_three_bit = strobe;
  assign bus.sample_one_bit   = 1'b0;
`else
  assign bus.sample_one_bit   = strobe;
  assign bus.sample_three_bit = 1'b0;
`endif

  assign bus.BIT_COUNT  = bit_cnt;
  assign bus.Data_valid = in_check && bus.stop_bit && !(par_en_q && bus.par_err);
  assign bus.stop_err   = in_check && !bus.stop_bit;
  assign bus.par_err_o  = in_check && par_en_q && bus.par_err;
  assign bus.busy       = (state_q != IDLE);
  assign state_o        = state_q;

endmodule

// File: tb/tb_rx_frame_ctrl.sv
// Bench for rx_frame_ctrl: directed frames plus randomized frames, each
// cycle compared against a timeline model derived from elapsed time since
// the frame's START entry.
module tb_rx_frame_ctrl;
  import rx_ctrl_pkg::*;

  localparam int PW = 6;

  logic      clk = 1'b0;
  logic      rst;
  rx_state_e state_dbg;

  rx_frame_ctrl_if #(.PRESCALE_W(PW)) bus ();

  rx_frame_ctrl #(.PRESCALE_W(PW)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .state_o (state_dbg)
  );

  // Clock and counters
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Scoreboard: expected {Data_valid, stop_err, par_err_o} for each frame.
  logic [2:0] exp_q[$];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_cycle(input int e_state, input int e_busy, input int e_bc,
                             input int e_strobe, input int e_dv, input int e_serr,
                             input int e_perr, input bit chk_bc);
    check_val("state", state_dbg, e_state);
    check_val("busy", bus.busy, e_busy);
    if (chk_bc) check_val("bit_count", bus.BIT_COUNT, e_bc);
`ifdef RX_MAJORITY_SAMPLE_EN
    check_val("sample_three", bus.sample_three_bit, e_strobe);
    check_val("sample_one", bus.sample_one_bit, 0);
`else
    check_val("sample_one", bus.sample_one_bit, e_strobe);
    check_val("sample_three", bus.sample_three_bit, 0);
`endif
    check_val("data_valid", bus.Data_valid, e_dv);
    check_val("stop_err", bus.stop_err, e_serr);
    check_val("par_err_o", bus.par_err_o, e_perr);
  endtask

  task automatic check_idle();
    check_cycle(IDLE, 0, 0, 0, 0, 0, 0, 1'b1);
  endtask

  // Drives one frame (called just after a rising edge) and checks every cycle.
  // cont: frame already started by the previous frame's CHECK cycle.
  // b2b: drive a start bit during this frame's CHECK cycle.
  // abort_rel: cycle offset at which to pulse rst (-1 for none).
  task automatic run_frame(input int p_in, input bit pe, input bit glitch,
                           input bit stop_v, input bit perr, input logic [7:0] data,
                           input bit cont, input bit b2b, input int nxt_p,
                           input bit nxt_pe, input int abort_rel);
    int p, total, k, e_state, dv_rel, bc_max;
    bit exp_dv, aborted;
    logic [2:0] exp_out;

    p       = (p_in < 4) ? 4 : p_in;
    total   = glitch ? p : (10 + int'(pe)) * p;
    exp_dv  = stop_v && !(pe && perr);
    aborted = 1'b0;
    bus.start_bit = glitch;
    bus.stop_bit  = stop_v;
    bus.par_err   = perr;
    if (!glitch) exp_q.push_back({exp_dv, !stop_v, pe && perr});

    if (!cont) begin
      bus.Prescale = PW'(p_in);
      bus.PAR_EN   = pe;
      bus.RX_IN    = 1'b1;
      repeat ($urandom_range(1, 3)) begin
        @(negedge clk);
        check_idle();
        @(posedge clk); #1;
      end
      bus.RX_IN = 1'b0;
      @(posedge clk); #1;
    end

    dv_rel = -1;
    bc_max = 0;
    for (int rel = 0; rel <= total; rel++) begin
      k = rel / p;
      if (rel == total)            bus.RX_IN = !(b2b && !glitch);
      else if (k == 0)             bus.RX_IN = glitch && (rel >= 1);
      else if (k <= 8)             bus.RX_IN = data[k-1];
      else if (pe && k == 9)       bus.RX_IN = ^data;
      else                         bus.RX_IN = 1'b1;

      if (rel == 1) begin
        bus.Prescale = PW'($urandom_range(0, 20));
        bus.PAR_EN   = 1'($urandom_range(0, 1));
      end
      if (rel == total - 1) begin
        bus.Prescale = PW'(b2b ? nxt_p : p_in);
        bus.PAR_EN   = b2b ? nxt_pe : pe;
      end
      if (rel == abort_rel) rst = 1'b1;

      @(negedge clk);
      if (rel == total) begin
        if (glitch) begin
          check_idle();
        end else begin
          exp_out = exp_q.pop_front();
          check_cycle(CHECK, 1, 0, 0, exp_out[2], exp_out[1], exp_out[0], 1'b0);
        end
      end else begin
        if (k == 0)            e_state = START;
        else if (k <= 8)       e_state = DATA;
        else if (pe && k == 9) e_state = PARITY;
        else                   e_state = STOP;
        check_cycle(e_state, 1, k, int'((rel % p) == (p / 2)), 0, 0, 0, 1'b1);
      end
      if (bus.Data_valid === 1'b1 && dv_rel < 0) dv_rel = rel;
      if (int'(bus.BIT_COUNT) > bc_max) bc_max = int'(bus.BIT_COUNT);
      @(posedge clk); #1;

      if (rel == abort_rel) begin
        rst          = 1'b0;
        bus.RX_IN    = 1'b1;
        bus.Prescale = PW'(p_in);
        @(negedge clk);
        check_idle();
        if (!glitch) void'(exp_q.pop_back());
        @(posedge clk); #1;
        aborted = 1'b1;
        break;
      end
    end

    if (!aborted) begin
      if (glitch) begin
        check_val("glitch_bc_max", bc_max, 0);
      end else begin
        check_val("bc_max", bc_max, 9 + int'(pe));
        if (exp_dv) check_val("dv_latency", dv_rel, total);
        else        check_val("dv_absent", dv_rel, -1);
      end
    end
  endtask

  int rp, np;
  bit rpe, npe, g, nb, cont;

  // Stimulus and final report
  initial begin
    rst           = 1'b1;
    bus.RX_IN     = 1'b1;
    bus.Prescale  = PW'(8);
    bus.PAR_EN    = 1'b0;
    bus.start_bit = 1'b0;
    bus.stop_bit  = 1'b1;
    bus.par_err   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check_idle();
    @(posedge clk); #1;
    rst = 1'b0;

    // 8 clocks/bit, no parity, 0xA5: Data_valid 80 clocks after START entry
    run_frame(8, 1'b0, 1'b0, 1'b1, 1'b0, 8'hA5, 1'b0, 1'b0, 0, 1'b0, -1);
    // 16 clocks/bit with parity error
    run_frame(16, 1'b1, 1'b0, 1'b1, 1'b1, 8'h5A, 1'b0, 1'b0, 0, 1'b0, -1);
    // Start-bit glitch
    run_frame(8, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 0, 1'b0, -1);
    // Bad stop bit
    run_frame(6, 1'b1, 1'b0, 1'b0, 1'b0, 8'hC3, 1'b0, 1'b0, 0, 1'b0, -1);
    // Back-to-back: second frame 0x3C starts from CHECK
    run_frame(8, 1'b0, 1'b0, 1'b1, 1'b0, 8'h96, 1'b0, 1'b1, 8, 1'b0, -1);
    run_frame(8, 1'b0, 1'b0, 1'b1, 1'b0, 8'h3C, 1'b1, 1'b0, 0, 1'b0, -1);
    // Reset while BIT_COUNT == 4
    run_frame(8, 1'b0, 1'b0, 1'b1, 1'b0, 8'hFF, 1'b0, 1'b0, 0, 1'b0, 4 * 8 + 2);
    // Prescale below the floor
    run_frame(2, 1'b0, 1'b0, 1'b1, 1'b0, 8'h11, 1'b0, 1'b0, 0, 1'b0, -1);
    run_frame(0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h22, 1'b0, 1'b0, 0, 1'b0, -1);

    // Randomized frames, occasionally chained back-to-back
    cont = 1'b0;
    rp   = $urandom_range(0, 20);
    rpe  = 1'($urandom_range(0, 1));
    for (int i = 0; i < 30; i++) begin
      g   = ($urandom_range(0, 5) == 0);
      nb  = !g && (i < 29) && ($urandom_range(0, 3) == 0);
      np  = $urandom_range(0, 20);
      npe = 1'($urandom_range(0, 1));
      run_frame(rp, rpe, g, $urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0,
                8'($urandom), cont, nb, np, npe, -1);
      cont = nb;
      rp   = np;
      rpe  = npe;
    end

    check_val("scoreboard_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
